// File: rtl/axi_top_pkg.sv
// Shared constants and types for the regex coprocessor register block.
package AXI_package;

  localparam int REG_WIDTH = 32;

  // Host command encodings
  localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ  = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_START = 32'd3;

  // Engine status; also used directly as the engine FSM state
  typedef enum logic [1:0] {
    STATUS_IDLE     = 2'd0,
    STATUS_RUNNING  = 2'd1,
    STATUS_ACCEPTED = 2'd2,
    STATUS_REJECTED = 2'd3
  } status_e;

  // Instruction types (upper byte of a code halfword)
  localparam logic [7:0] INSTR_ACCEPT                = 8'h00;
  localparam logic [7:0] INSTR_SPLIT                 = 8'h01;
  localparam logic [7:0] INSTR_MATCH_CHAR            = 8'h02;
  localparam logic [7:0] INSTR_JMP                   = 8'h03;
  localparam logic [7:0] INSTR_END_WITHOUT_ACCEPTING = 8'h04;
  localparam logic [7:0] INSTR_MATCH_ANY             = 8'h05;
  localparam logic [7:0] INSTR_ACCEPT_PARTIAL        = 8'h06;
  localparam logic [7:0] INSTR_NOT_MATCH             = 8'h07;

  // One memory halfword viewed as an instruction
  typedef struct packed {
    logic [7:0] op;
    logic [7:0] data;
  } instr_t;

endpackage

// File: rtl/axi_top_stack.sv
// LIFO of (pc, cc) backtrack points for the regex engine.
module regex_backtrack_stack #(
  parameter int STACK_DEPTH = 16,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [ADDR_W-1:0] push_cc,
  output logic [ADDR_W-1:0] top_pc,
  output logic [ADDR_W-1:0] top_cc,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] cc_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  top_idx;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == PTR_W'(STACK_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top_idx = count - PTR_W'(1);
  assign top_pc  = pc_mem[top_idx[IDX_W-1:0]];
  assign top_cc  = cc_mem[top_idx[IDX_W-1:0]];

  // Occupancy count; clear empties the stack at the start of every run
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + PTR_W'(1);
    end else if (do_pop) begin
      count <= count - PTR_W'(1);
    end
  end

  // Entry storage is never reset; only the count decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[count[IDX_W-1:0]] <= push_pc;
      cc_mem[count[IDX_W-1:0]] <= push_cc;
    end
  end

endmodule

// File: rtl/axi_top.sv
// Register-driven regex coprocessor: shared code/string memory, host
// write/read access and a one-instruction-per-cycle backtracking engine.
module axi_top
  import AXI_package::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int STACK_DEPTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_WIDTH-1:0] data_in_register,
  input  logic [REG_WIDTH-1:0] address_register,
  input  logic [REG_WIDTH-1:0] start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0] cmd_register,
  output logic [REG_WIDTH-1:0] status_register,
  output logic [REG_WIDTH-1:0] data_o_register
);

  localparam int AW = MEM_ADDR_WIDTH;

  logic [15:0]   mem [2**AW];

  status_e       state, state_nxt;
  logic [AW-1:0] pc, cc, pc_nxt, cc_nxt;
  instr_t        instr;
  logic [7:0]    ch;
  logic [AW-1:0] host_addr, host_addr_hi;
  logic          is_write, is_read, is_start;
  logic          stk_push, stk_pop, stk_clear, stk_empty, stk_full;
  logic [AW-1:0] stk_top_pc, stk_top_cc;
  logic          fail;
  logic          unused_reg_bits;

  assign host_addr    = address_register[AW-1:0];
  assign host_addr_hi = host_addr + AW'(1);
  assign is_write     = (cmd_register == CMD_WRITE);
  assign is_read      = (cmd_register == CMD_READ);
  assign is_start     = (cmd_register == CMD_START);

  // Two asynchronous read ports: instruction at pc, character at cc
  assign instr = mem[pc];
  assign ch    = mem[cc][7:0];

  assign status_register = {{(REG_WIDTH-2){1'b0}}, state};

  assign unused_reg_bits = ^{address_register[REG_WIDTH-1:AW],
                             start_cc_pointer_register[REG_WIDTH-1:AW]};

  regex_backtrack_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (AW)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .clear   (stk_clear),
    .push    (stk_push),
    .pop     (stk_pop),
    .push_pc (AW'(instr.data)),
    .push_cc (cc),
    .top_pc  (stk_top_pc),
    .top_cc  (stk_top_cc),
    .empty   (stk_empty),
    .full    (stk_full)
  );

  // Host writes store a halfword pair; locked out while the engine runs
  always_ff @(posedge clk) begin
    if (is_write && (state != STATUS_RUNNING)) begin
      mem[host_addr]    <= data_in_register[15:0];
      mem[host_addr_hi] <= data_in_register[31:16];
    end
  end

  // Host read-back register, one cycle latency, holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      data_o_register <= '0;
    end else if (is_read) begin
      data_o_register <= {16'b0, mem[host_addr]};
    end
  end

  // Engine state, program counter and character cursor
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATUS_IDLE;
      pc    <= '0;
      cc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cc    <= cc_nxt;
    end
  end

  // Start decode, instruction execution and backtracking on failure
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cc_nxt    = cc;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;
    fail      = 1'b0;
    if (state == STATUS_RUNNING) begin
      case (instr.op)
        INSTR_ACCEPT: begin
          if (ch == 8'd0) state_nxt = STATUS_ACCEPTED;
          else            fail = 1'b1;
        end
        INSTR_SPLIT: begin
          if (stk_full) begin
            state_nxt = STATUS_REJECTED;
          end else begin
            stk_push = 1'b1;
            pc_nxt   = pc + AW'(1);
          end
        end
        INSTR_MATCH_CHAR: begin
          if (ch == instr.data) begin
            pc_nxt = pc + AW'(1);
            cc_nxt = cc + AW'(1);
          end else begin
            fail = 1'b1;
          end
        end
        INSTR_JMP: pc_nxt = AW'(instr.data);
        INSTR_MATCH_ANY: begin
          if (ch != 8'd0) begin
            pc_nxt = pc + AW'(1);
            cc_nxt = cc + AW'(1);
          end else begin
            fail = 1'b1;
          end
        end
        INSTR_ACCEPT_PARTIAL: state_nxt = STATUS_ACCEPTED;
        INSTR_NOT_MATCH: begin
          if ((ch != 8'd0) && (ch != instr.data)) begin
            pc_nxt = pc + AW'(1);
            cc_nxt = cc + AW'(1);
          end else begin
            fail = 1'b1;
          end
        end
        default: fail = 1'b1;
      endcase
      if (fail) begin
        if (stk_empty) begin
          state_nxt = STATUS_REJECTED;
        end else begin
          stk_pop = 1'b1;
          pc_nxt  = stk_top_pc;
          cc_nxt  = stk_top_cc;
        end
      end
    end else if (is_start) begin
      state_nxt = STATUS_RUNNING;
      pc_nxt    = '0;
      cc_nxt    = start_cc_pointer_register[AW-1:0];
      stk_clear = 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_top.sv
// Scoreboard bench for axi_top: a driver queues expectations, a monitor
// compares them against the DUT outputs when they are due.
module tb_axi_top;
  import AXI_package::*;

  localparam int MEM_N = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in_register, address_register;
  logic [31:0] start_cc_pointer_register, cmd_register;
  logic [31:0] status_register, data_o_register;

  axi_top dut (
    .clk                       (clk),
    .reset                     (reset),
    .data_in_register          (data_in_register),
    .address_register          (address_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .cmd_register              (cmd_register),
    .status_register           (status_register),
    .data_o_register           (data_o_register)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          is_status;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] run_q[$];
  string       run_name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem_m [MEM_N];

  // Reference: interpret the program from the ISA rules over the model memory
  function automatic logic [31:0] run_model(input int cc0);
    int pc, cc, t, d, ch;
    int spc[$];
    int scc[$];
    bit fl;
    pc = 0;
    cc = cc0 % MEM_N;
    for (int step = 0; step < 100000; step++) begin
      t  = int'(mem_m[pc][15:8]);
      d  = int'(mem_m[pc][7:0]);
      ch = int'(mem_m[cc][7:0]);
      fl = 1'b0;
      case (t)
        0: if (ch == 0) return 32'd2; else fl = 1'b1;
        1: begin
          if (spc.size() >= 16) return 32'd3;
          spc.push_back(d);
          scc.push_back(cc);
          pc = (pc + 1) % MEM_N;
        end
        2: if (ch == d) begin pc = (pc + 1) % MEM_N; cc = (cc + 1) % MEM_N; end
           else fl = 1'b1;
        3: pc = d;
        5: if (ch != 0) begin pc = (pc + 1) % MEM_N; cc = (cc + 1) % MEM_N; end
           else fl = 1'b1;
        6: return 32'd2;
        7: if (ch != 0 && ch != d) begin pc = (pc + 1) % MEM_N; cc = (cc + 1) % MEM_N; end
           else fl = 1'b1;
        default: fl = 1'b1;
      endcase
      if (fl) begin
        if (spc.size() == 0) return 32'd3;
        pc = spc.pop_back();
        cc = scc.pop_back();
      end
    end
    return 32'hFFFF_FFFF;
  endfunction

  // Monitor: due-cycle checks plus final status whenever a run ends
  logic [31:0] prev_status = 32'd0;
  chk_t        mc;
  logic [31:0] act, rexp;
  string       rname;
  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
      mc  = chk_q.pop_front();
      act = mc.is_status ? status_register : data_o_register;
      checks++;
      if (mc.due != cyc) begin
        errors++;
        $display("FAIL %s: check missed at cycle %0d (due %0d)", mc.name, cyc, mc.due);
      end else if (act !== mc.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", mc.name, act, mc.exp);
      end
    end
    if (prev_status == 32'd1 && (status_register == 32'd2 || status_register == 32'd3)) begin
      checks++;
      if (run_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_run_end: got %h, expected no run end", status_register);
      end else begin
        rexp  = run_q.pop_front();
        rname = run_name_q.pop_front();
        if (status_register !== rexp) begin
          errors++;
          $display("FAIL %s: got status %h, expected %h", rname, status_register, rexp);
        end
      end
    end
    prev_status = status_register;
  end

  task automatic expect_next(input bit is_status, input logic [31:0] exp, input string nm);
    chk_t c;
    c.due       = cyc + 1;
    c.is_status = is_status;
    c.exp       = exp;
    c.name      = nm;
    chk_q.push_back(c);
  endtask

  task automatic tick(input logic [31:0] cmd, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] scc);
    @(posedge clk);
    #1;
    cmd_register              = cmd;
    address_register          = addr;
    data_in_register          = data;
    start_cc_pointer_register = scc;
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input bit running);
    tick(CMD_WRITE, 32'(addr), data, 32'd0);
    if (!running) begin
      mem_m[addr % MEM_N]       = data[15:0];
      mem_m[(addr + 1) % MEM_N] = data[31:16];
    end
  endtask

  task automatic do_read(input int addr, input string nm);
    tick(CMD_READ, 32'(addr), 32'd0, 32'd0);
    expect_next(1'b0, {16'b0, mem_m[addr % MEM_N]}, nm);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    cmd_register = CMD_NOP;
    expect_next(1'b1, 32'd0, {nm, "_status"});
    expect_next(1'b0, 32'd0, {nm, "_data_o"});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_run(input int scc, input logic [31:0] exp, input string nm);
    tick(CMD_START, 32'd0, 32'd0, 32'(scc));
    expect_next(1'b1, 32'd1, {nm, "_running"});
    run_q.push_back(exp);
    run_name_q.push_back(nm);
    tick(CMD_NOP, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3000 && run_q.size() > 0; i++) @(posedge clk);
    if (run_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: run did not finish, status %h, expected %h", nm, status_register, exp);
      void'(run_q.pop_front());
      void'(run_name_q.pop_front());
      do_reset({nm, "_recover"});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] img [14];
    logic [15:0] str [8];
    int L, slen, t, d;

    for (int i = 0; i < MEM_N; i++) mem_m[i] = 16'h0000;
    reset                     = 1'b1;
    cmd_register              = CMD_NOP;
    address_register          = 32'd0;
    data_in_register          = 32'd0;
    start_cc_pointer_register = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset and idle
    do_reset("t1_reset");
    tick(CMD_NOP, 32'd0, 32'd0, 32'd0);
    expect_next(1'b1, 32'd0, "t1_idle_status");

    // 2: write then read back both halfwords
    do_write(0, 32'h0000_0261, 1'b0);
    tick(CMD_READ, 32'd0, 32'd0, 32'd0);
    expect_next(1'b0, 32'h0000_0261, "t2_read_a0");
    tick(CMD_READ, 32'd1, 32'd0, 32'd0);
    expect_next(1'b0, 32'h0000_0000, "t2_read_a1");
    tick(CMD_NOP, 32'd0, 32'd0, 32'd0);
    expect_next(1'b0, 32'h0000_0000, "t2_hold");

    // 3: single-character match
    do_write(2, 32'h0000_0061, 1'b0);
    do_run(2, 32'd2, "t3_match_a");
    do_write(2, 32'h0000_0062, 1'b0);
    do_run(2, 32'd3, "t3_reject_b");

    // 4: alternation a|b with backtracking
    do_write(0, 32'h0261_0103, 1'b0);
    do_write(2, 32'h0262_0000, 1'b0);
    do_write(4, 32'h0400_0000, 1'b0);
    do_write(8, 32'h0000_0062, 1'b0);
    do_run(8, 32'd2, "t4_b");
    do_write(8, 32'h0000_0063, 1'b0);
    do_run(8, 32'd3, "t4_c");
    do_write(8, 32'h0062_0061, 1'b0);
    do_write(10, 32'h0000_0000, 1'b0);
    do_run(8, 32'd3, "t4_ab");

    // 5: 17 SPLITs overflow a 16-deep stack
    for (int i = 0; i < 18; i += 2)
      do_write(i, {(i + 1 < 17) ? 16'h0111 : 16'h0600, 16'h0111}, 1'b0);
    do_write(100, 32'h0000_0000, 1'b0);
    do_run(100, 32'd3, "t5_overflow");

    // 6: endless JMP 0 loop; writes and START ignored, reset stops it
    do_write(20, 32'hBEEF_1234, 1'b0);
    do_write(0, 32'h0000_0300, 1'b0);
    tick(CMD_START, 32'd0, 32'd0, 32'd0);
    expect_next(1'b1, 32'd1, "t6_running");
    do_write(20, 32'hAAAA_5555, 1'b1);
    tick(CMD_START, 32'd0, 32'd0, 32'd5);
    expect_next(1'b1, 32'd1, "t6_start_ignored");
    do_read(20, "t6_read_while_running");
    do_reset("t6_reset_midrun");
    do_read(20, "t6_mem_lo_kept");
    do_read(21, "t6_mem_hi_kept");

    // 7: random terminating programs against the reference interpreter
    for (int it = 0; it < 30; it++) begin
      L = $urandom_range(3, 11);
      for (int p = 0; p < L; p++) begin
        t = $urandom_range(0, 8);
        case (t)
          1, 3:    d = $urandom_range(p + 1, L);
          2, 7:    d = 97 + $urandom_range(0, 2);
          default: d = $urandom_range(0, 255);
        endcase
        img[p] = {8'(t), 8'(d)};
      end
      img[L]     = 16'h0400;
      img[L + 1] = 16'h0400;
      for (int p = 0; p <= L; p += 2) do_write(p, {img[p + 1], img[p]}, 1'b0);
      slen = $urandom_range(0, 5);
      for (int s = 0; s < 8; s++)
        str[s] = (s < slen) ? 16'(97 + $urandom_range(0, 2)) : 16'h0000;
      for (int s = 0; s < 8; s += 2) do_write(64 + s, {str[s + 1], str[s]}, 1'b0);
      do_read($urandom_range(0, L), "rand_readback");
      do_run(64, run_model(64), "rand_run");
    end

    tick(CMD_NOP, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
